// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, requester IDs, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    // Default data word width and memory word address width
    localparam int DMEM_WIDTH  = 32;
    localparam int DMEM_ADDR_W = 8;

    // Requester identifiers; also the index of each requester in the request vector
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Arbiter FSM: IDLE samples requests, ACCESS drives the memory strobe, RESP returns read data
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester that did not win; used to hand preference to the other side after a grant
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-requester winner select: request vector plus preferred-requester pointer -> one-hot grant.
// Latency: purely combinational.
// Backpressure: none; an empty request vector yields an all-zero grant.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Preferred requester wins if it is asking, otherwise the other one; at most one bit set
    always_comb begin
        gnt = 2'b00;
        if (ptr == REQ_CORE) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end else begin
            if (req[1]) begin
                gnt = 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core load/store + debug/DMA) onto one single-port memory.
// Latency: gnt and memory strobe one cycle after request sampled in IDLE; rvalid one cycle later.
// Backpressure: a requester holds req until its gnt pulse; writes occupy 2 cycles, reads 3.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration (default is fixed priority, m0 wins).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH  = DMEM_WIDTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [WIDTH-1:0]  m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [WIDTH-1:0]  m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [WIDTH-1:0]  m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [WIDTH-1:0]  m1_rdata,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        req_vec;
    logic [1:0]        pick_gnt;
    logic              ptr;
    logic              win_id;
    logic              take;
    logic              owner;
    logic              op_we;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    assign req_vec = {m1_req, m0_req};

    dmem_arb_pick u_pick (
        .req (req_vec),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    // Winner index from the one-hot grant, and its command fields
    assign win_id    = pick_gnt[REQ_DBG];
    assign sel_we    = (win_id == REQ_DBG) ? m1_we    : m0_we;
    assign sel_addr  = (win_id == REQ_DBG) ? m1_addr  : m0_addr;
    assign sel_wdata = (win_id == REQ_DBG) ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // Preference flips to the requester that lost (or did not ask) on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_CORE;
        end else if (take) begin
            rr_ptr <= other_req(win_id);
        end
    end

    assign ptr = rr_ptr;
`else
    // Fixed priority: the core is always preferred on a tie
    assign ptr = REQ_CORE;
`endif

    // FSM state register; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: requests are only looked at in IDLE; reads take an extra RESP cycle
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (|pick_gnt) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = op_we ? IDLE : RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory command register: strobes live for the ACCESS cycle only, address/data hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= REQ_CORE;
            op_we     <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (take) begin
                owner     <= win_id;
                op_we     <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_we    <= sel_we;
                mem_re    <= ~sel_we;
            end
        end
    end

    // Grant pulses in ACCESS, read-valid pulses in RESP, both steered to the owner
    assign m0_gnt    = (state == ACCESS) && (owner == REQ_CORE);
    assign m1_gnt    = (state == ACCESS) && (owner == REQ_DBG);
    assign m0_rvalid = (state == RESP)   && (owner == REQ_CORE);
    assign m1_rvalid = (state == RESP)   && (owner == REQ_DBG);

    // Read data is passed straight through from the memory
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

endmodule
